// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one divider among N_REQ requesters.
// Latches operands at grant, issues start, waits with a watchdog.
module divider_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 10,
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               sclr,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_flat,
  input  logic [N_REQ*W-1:0] b_flat,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       res_q,
  output logic               res_dvz,
  output logic               res_ovf,
  output logic               res_err,
  output logic               div_start,
  output logic               div_sclr,
  output logic [W-1:0]       div_a,
  output logic [W-1:0]       div_b,
  input  logic               div_busy,
  input  logic               div_valid,
  input  logic               div_dvz,
  input  logic               div_ovf,
  input  logic [W-1:0]       div_q
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [5:0] WD_MAX = 6'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ABORT
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    ptr_d;
  logic [IW-1:0]    pick;
  logic             found;
  logic [N_REQ-1:0] onehot;
  logic [5:0]       wd_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic [W-1:0]     rq_q;
  logic             dvz_q;
  logic             ovf_q;
  logic             err_q;
  logic             start_q;
  logic             clr_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             cmpl;
  logic             unused_busy;

  assign unused_busy = div_busy;
  assign cmpl = div_valid | div_dvz | div_ovf;

  // First set request at or after ptr, wrapping.
  always_comb begin
    int j;
    j     = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j -= N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
  assign ptr_d  = (idx_q == IW'(N_REQ-1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rq_q    <= '0;
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      start_q <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= '0;
      unique case (state_q)
        S_IDLE: if (found) begin
          gnt_q   <= onehot;
          idx_q   <= pick;
          a_q     <= a_flat[pick*W +: W];
          b_q     <= b_flat[pick*W +: W];
          start_q <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: if (cmpl) begin
          rq_q    <= div_q;
          dvz_q   <= div_dvz;
          ovf_q   <= div_ovf;
          err_q   <= 1'b0;
          done_q  <= gnt_q;
          state_q <= S_DONE;
        end else begin
          wd_q <= wd_q + 6'd1;
          if (wd_q + 6'd1 == WD_MAX) begin
            rq_q    <= '0;
            dvz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= gnt_q;
            clr_q   <= 1'b1;
            state_q <= S_ABORT;
          end
        end
        S_DONE, S_ABORT: begin
          gnt_q   <= '0;
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign res_q     = rq_q;
  assign res_dvz   = dvz_q;
  assign res_ovf   = ovf_q;
  assign res_err   = err_q;
  assign div_start = start_q;
  assign div_sclr  = clr_q;
  assign div_a     = a_q;
  assign div_b     = b_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter with a behavioural divider
// that can complete, flag divide-by-zero, or hang.
module tb_divider_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic [9:0] q;
    logic       dvz;
    logic       err;
  } exp_t;

  logic        clk = 0;
  logic        sclr;
  logic [3:0]  req;
  logic [39:0] a_flat;
  logic [39:0] b_flat;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [9:0]  res_q;
  logic        res_dvz;
  logic        res_ovf;
  logic        res_err;
  logic        div_start;
  logic        div_sclr;
  logic [9:0]  div_a;
  logic [9:0]  div_b;
  logic        div_busy  = 0;
  logic        div_valid = 0;
  logic        div_dvz   = 0;
  logic        div_ovf   = 0;
  logic [9:0]  div_q     = 0;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_done = -1;
  int   op_starts = 0;
  int   nsclr = 0;
  bit   keep = 0;
  bit   hang = 0;
  int   lat = 2;
  logic [3:0] prev_gnt = 0;

  logic       mbusy = 0;
  int         mcnt = 0;
  logic [9:0] ma = 0;
  logic [9:0] mb = 0;

  divider_arbiter #(.N_REQ(4), .W(10), .TIMEOUT(63)) dut (
    .clk(clk), .sclr(sclr), .req(req),
    .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .done(done), .res_q(res_q),
    .res_dvz(res_dvz), .res_ovf(res_ovf), .res_err(res_err),
    .div_start(div_start), .div_sclr(div_sclr),
    .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_valid(div_valid),
    .div_dvz(div_dvz), .div_ovf(div_ovf), .div_q(div_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(logic [3:0] g, logic [9:0] q, logic dz, logic er);
    exp_t e;
    e.gnt = g; e.q = q; e.dvz = dz; e.err = er;
    sb.push_back(e);
  endtask

  task automatic set_op(int i, logic [9:0] a, logic [9:0] b);
    a_flat[i*10 +: 10] = a;
    b_flat[i*10 +: 10] = b;
  endtask

  task automatic drain(int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_gnt(int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (gnt != 0) break;
    end
    check("gnt_seen", (gnt != 0), 1);
  endtask

  task automatic reset_checks(string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_res"}, {res_q, res_dvz, res_ovf, res_err}, 0);
    check({tag, "_ctl"}, {div_start, div_sclr}, 0);
    check({tag, "_ops"}, {div_a, div_b}, 0);
  endtask

  // Behavioural divider driven away from the active edge.
  always @(negedge clk) begin
    div_valid = 0;
    div_dvz   = 0;
    div_ovf   = 0;
    if (sclr || div_sclr) begin
      mbusy = 0;
    end else if (div_start) begin
      ma = div_a; mb = div_b; mcnt = lat; mbusy = 1;
    end else if (mbusy && !hang) begin
      if (mcnt <= 1) begin
        mbusy = 0;
        if (mb == 0) begin
          div_dvz = 1; div_q = 10'h3FF;
        end else begin
          div_valid = 1; div_q = ma / mb;
        end
      end else begin
        mcnt--;
      end
    end
    div_busy = mbusy;
  end

  // Output monitor and scoreboard compare.
  always @(negedge clk) begin
    if (!sclr) begin
      if (gnt != 0 && prev_gnt == 0) begin
        op_starts = 0;
        check("start_at_grant", div_start, 1);
        if (keep && last_done >= 0)
          check("idle_gap", cyc - last_done, 2);
      end
      if (div_start) begin
        op_starts++;
        start_cyc = cyc;
      end
      if (div_sclr) begin
        nsclr++;
        check("wd_lat", cyc - start_cyc, 64);
      end
      if (done != 0) begin
        last_done = cyc;
        if (sb.size() == 0) begin
          check("extra_done", done, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done", done, e.gnt);
          check("gnt_at_done", gnt, e.gnt);
          check("one_start", op_starts, 1);
          check("res_q", res_q, e.q);
          check("res_flags", {res_dvz, res_ovf, res_err},
                {e.dvz, 1'b0, e.err});
          if (sb.size() == 0) req = 0;
          else if (!keep) req = req & ~done;
        end
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    sclr = 1; req = 0; a_flat = 0; b_flat = 0;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    sclr = 0;
    @(negedge clk);

    set_op(0, 100, 7);
    push(4'b0001, 14, 0, 0);
    req = 4'b0001;
    drain(100);
    repeat (3) @(negedge clk);

    sclr = 1; @(negedge clk); sclr = 0; @(negedge clk);
    set_op(0, 200, 10); set_op(1, 300, 7);
    set_op(2, 400, 9);  set_op(3, 500, 3);
    push(4'b0001, 20, 0, 0);  push(4'b0010, 42, 0, 0);
    push(4'b0100, 44, 0, 0);  push(4'b1000, 166, 0, 0);
    push(4'b0001, 20, 0, 0);
    keep = 1; last_done = -1;
    req = 4'b1111;
    drain(200);
    keep = 0;
    repeat (3) @(negedge clk);

    set_op(2, 123, 0);
    push(4'b0100, 10'h3FF, 1, 0);
    req = 4'b0100;
    drain(100);
    repeat (2) @(negedge clk);
    set_op(0, 60, 6);
    push(4'b0001, 10, 0, 0);
    req = 4'b0001;
    drain(100);
    repeat (2) @(negedge clk);

    hang = 1;
    set_op(3, 77, 7);
    push(4'b1000, 0, 0, 1);
    req = 4'b1000;
    drain(200);
    hang = 0;
    repeat (2) @(negedge clk);

    set_op(0, 50, 5);
    push(4'b0001, 10, 0, 0);
    req = 4'b0001;
    wait_gnt(20);
    @(negedge clk);
    a_flat[9:0] = 10'd999;
    @(negedge clk);
    check("div_a_held", div_a, 50);
    drain(100);
    repeat (2) @(negedge clk);

    hang = 1;
    req = 4'b0001;
    wait_gnt(20);
    repeat (5) @(negedge clk);
    #2 sclr = 1;
    #1 reset_checks("async_rst");
    req = 0;
    @(negedge clk);
    @(negedge clk);
    sclr = 0; hang = 0;
    push(4'b0010, 42, 0, 0);
    req = 4'b0010;
    wait_gnt(20);
    check("gnt_after_rst", gnt, 4'b0010);
    drain(100);
    repeat (3) @(negedge clk);

    check("sclr_pulses", nsclr, 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
